// File: rtl/cntr_sweep_ctrl.sv
// Triangle-sweep sequencer: drives an up/down counter lo->hi->lo for a
// programmed number of repeats, with optional dwell at both turning points.
module cntr_sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int REPS_W  = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [WIDTH-1:0]   cfg_lo_i,
    input  logic [WIDTH-1:0]   cfg_hi_i,
    input  logic [REPS_W-1:0]  cfg_reps_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [WIDTH-1:0]   cntr_o,
    output logic               dir_o,
    output logic               busy_o,
    output logic [REPS_W-1:0]  sweep_cnt_o,
    output logic               done_o,
    output logic               err_o,
    output logic               abort_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] UP       = 3'd2;
    localparam logic [2:0] DWELL_HI = 3'd3;
    localparam logic [2:0] DOWN     = 3'd4;
    localparam logic [2:0] DWELL_LO = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam logic [WIDTH-1:0]   CNT_ONE = 1;
    localparam logic [REPS_W-1:0]  REP_ONE = 1;
    localparam logic [DWELL_W-1:0] DW_ONE  = 1;

    logic [2:0]         state;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [REPS_W-1:0]  reps_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;

    logic               bad_cfg;
    logic               can_abort;
    logic               dwell_zero;
    logic [REPS_W-1:0]  sweep_next;

    assign bad_cfg    = (cfg_lo_i >= cfg_hi_i) || (cfg_reps_i == '0);
    assign can_abort  = (state != IDLE) && (state != DONE);
    assign dwell_zero = (dwell_q == '0);
    assign sweep_next = sweep_cnt_o + REP_ONE;

    assign dir_o  = (state == UP);
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            reps_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
            cntr_o      <= '0;
            sweep_cnt_o <= '0;
            err_o       <= 1'b0;
            abort_o     <= 1'b0;
        end else begin
            err_o   <= 1'b0;
            abort_o <= 1'b0;
            // Abort wins over normal sequencing; counter and sweep count freeze.
            if (abort_i && can_abort) begin
                state   <= IDLE;
                abort_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            if (bad_cfg) begin
                                err_o <= 1'b1;
                            end else begin
                                lo_q        <= cfg_lo_i;
                                hi_q        <= cfg_hi_i;
                                reps_q      <= cfg_reps_i;
                                dwell_q     <= cfg_dwell_i;
                                sweep_cnt_o <= '0;
                                state       <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        cntr_o <= lo_q;
                        state  <= UP;
                    end
                    UP: begin
                        if (cntr_o != hi_q) begin
                            cntr_o <= cntr_o + CNT_ONE;
                        end else if (dwell_zero) begin
                            state <= DOWN;
                        end else begin
                            dwell_cnt <= dwell_q - DW_ONE;
                            state     <= DWELL_HI;
                        end
                    end
                    DWELL_HI: begin
                        if (dwell_cnt == '0) state <= DOWN;
                        else dwell_cnt <= dwell_cnt - DW_ONE;
                    end
                    DOWN: begin
                        if (cntr_o != lo_q) begin
                            cntr_o <= cntr_o - CNT_ONE;
                        end else begin
                            sweep_cnt_o <= sweep_next;
                            if (sweep_next == reps_q) begin
                                state <= DONE;
                            end else if (dwell_zero) begin
                                state <= UP;
                            end else begin
                                dwell_cnt <= dwell_q - DW_ONE;
                                state     <= DWELL_LO;
                            end
                        end
                    end
                    DWELL_LO: begin
                        if (dwell_cnt == '0) state <= UP;
                        else dwell_cnt <= dwell_cnt - DW_ONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cntr_sweep_ctrl.sv
// Randomized bench for cntr_sweep_ctrl against a trace-generating
// reference model built from the sweep rules.
module tb_cntr_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_lo;
    logic [7:0] cfg_hi;
    logic [7:0] cfg_reps;
    logic [3:0] cfg_dwell;
    logic       start;
    logic       abort;
    logic [7:0] cntr;
    logic       dir;
    logic       busy;
    logic [7:0] sweep_cnt;
    logic       done;
    logic       err;
    logic       abrt;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_cntr;

    // st: 0 idle, 1 load, 2 up, 3 dwell, 4 down, 5 done
    typedef struct {
        int         st;
        logic [7:0] c;
        logic       d;
        logic       b;
        logic       dn;
        logic [7:0] s;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    cntr_sweep_ctrl #(.WIDTH(8), .REPS_W(8), .DWELL_W(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cfg_lo_i   (cfg_lo),
        .cfg_hi_i   (cfg_hi),
        .cfg_reps_i (cfg_reps),
        .cfg_dwell_i(cfg_dwell),
        .start_i    (start),
        .abort_i    (abort),
        .cntr_o     (cntr),
        .dir_o      (dir),
        .busy_o     (busy),
        .sweep_cnt_o(sweep_cnt),
        .done_o     (done),
        .err_o      (err),
        .abort_o    (abrt)
    );

    function automatic void push(int st, logic [7:0] c, logic d,
                                 logic b, logic dn, logic [7:0] s);
        exp_t e;
        e.st = st;
        e.c  = c;
        e.d  = d;
        e.b  = b;
        e.dn = dn;
        e.s  = s;
        q.push_back(e);
    endfunction

    // Expected per-cycle outputs, starting with the cycle after start is accepted.
    function automatic void build(int lo, int hi, int reps, int dwell);
        q.delete();
        push(1, model_cntr, 0, 1, 0, 8'd0);
        for (int r = 0; r < reps; r++) begin
            for (int v = lo; v <= hi; v++) push(2, 8'(v), 1, 1, 0, 8'(r));
            for (int k = 0; k < dwell; k++) push(3, 8'(hi), 0, 1, 0, 8'(r));
            for (int v = hi; v >= lo; v--) push(4, 8'(v), 0, 1, 0, 8'(r));
            if (r < reps - 1)
                for (int k = 0; k < dwell; k++)
                    push(3, 8'(lo), 0, 1, 0, 8'(r + 1));
        end
        push(5, 8'(lo), 0, 1, 1, 8'(reps));
        push(0, 8'(lo), 0, 0, 0, 8'(reps));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_lo = '0;
        cfg_hi = '0;
        cfg_reps = '0;
        cfg_dwell = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cntr, dir, busy, done, err, abrt, sweep_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h required 0",
                     {cntr, dir, busy, done, err, abrt, sweep_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cntr, dir, busy, done, err, abrt, sweep_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL reset_release: got %h required 0",
                     {cntr, dir, busy, done, err, abrt, sweep_cnt});
        end
        model_cntr = 8'd0;
    endtask

    task automatic run_sweep(string name, int lo, int hi, int reps,
                             int dwell, bit noise, bit with_abort);
        logic [20:0] got;
        logic [20:0] exp;
        build(lo, hi, reps, dwell);
        @(negedge clk);
        cfg_lo = 8'(lo);
        cfg_hi = 8'(hi);
        cfg_reps = 8'(reps);
        cfg_dwell = 4'(dwell);
        start = 1'b1;
        abort = with_abort;
        foreach (q[i]) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (noise && q[i].st != 0) begin
                start = 1'($urandom % 2);
                cfg_lo = 8'($urandom);
                cfg_hi = 8'($urandom);
                cfg_reps = 8'($urandom);
                cfg_dwell = 4'($urandom);
            end
            got = {cntr, dir, busy, done, err, abrt, sweep_cnt};
            exp = {q[i].c, q[i].d, q[i].b, q[i].dn, 1'b0, 1'b0, q[i].s};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h",
                         name, i, got, exp);
            end
        end
        start = 1'b0;
        model_cntr = 8'(lo);
    endtask

    task automatic test_bad_cfg(string name, int lo, int hi, int reps);
        @(negedge clk);
        cfg_lo = 8'(lo);
        cfg_hi = 8'(hi);
        cfg_reps = 8'(reps);
        cfg_dwell = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({err, busy, done, abrt, cntr} !== {4'b1000, model_cntr}) begin
            errors++;
            $display("FAIL %s_err: got %h required %h", name,
                     {err, busy, done, abrt, cntr}, {4'b1000, model_cntr});
        end
        @(negedge clk);
        checks++;
        if ({err, busy, cntr} !== {2'b00, model_cntr}) begin
            errors++;
            $display("FAIL %s_after: got %h required %h", name,
                     {err, busy, cntr}, {2'b00, model_cntr});
        end
    endtask

    task automatic test_abort();
        int idx;
        build(1, 6, 2, 1);
        @(negedge clk);
        cfg_lo = 8'd1;
        cfg_hi = 8'd6;
        cfg_reps = 8'd2;
        cfg_dwell = 4'd1;
        start = 1'b1;
        idx = 0;
        while (idx < q.size()) begin
            @(negedge clk);
            start = 1'($urandom % 2);
            cfg_lo = 8'($urandom);
            checks++;
            if ({cntr, busy, done} !== {q[idx].c, q[idx].b, q[idx].dn}) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %h required %h", idx,
                         {cntr, busy, done}, {q[idx].c, q[idx].b, q[idx].dn});
            end
            if (q[idx].st == 4 && q[idx].c == 8'd3) break;
            idx++;
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({cntr, dir, busy, done, err, abrt, sweep_cnt}
            !== {8'd3, 5'b00001, 8'd0}) begin
            errors++;
            $display("FAIL abort_pulse: got %h required %h",
                     {cntr, dir, busy, done, err, abrt, sweep_cnt},
                     {8'd3, 5'b00001, 8'd0});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({cntr, busy, done, abrt} !== {8'd3, 3'b000}) begin
                errors++;
                $display("FAIL abort_after: got %h required %h",
                         {cntr, busy, done, abrt}, {8'd3, 3'b000});
            end
        end
        model_cntr = 8'd3;
    endtask

    task automatic test_reset_mid();
        int idx;
        build(1, 8, 1, 0);
        @(negedge clk);
        cfg_lo = 8'd1;
        cfg_hi = 8'd8;
        cfg_reps = 8'd1;
        cfg_dwell = 4'd0;
        start = 1'b1;
        idx = 0;
        while (idx < q.size()) begin
            @(negedge clk);
            start = 1'b0;
            if (q[idx].st == 2 && q[idx].c == 8'd4) break;
            idx++;
        end
        checks++;
        if ({cntr, dir} !== {8'd4, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_pre: got %h required %h",
                     {cntr, dir}, {8'd4, 1'b1});
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({cntr, dir, busy, done, err, abrt, sweep_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid: got %h required 0",
                     {cntr, dir, busy, done, err, abrt, sweep_cnt});
        end
        @(negedge clk);
        checks++;
        if ({cntr, dir, busy, done, err, abrt, sweep_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid_after: got %h required 0",
                     {cntr, dir, busy, done, err, abrt, sweep_cnt});
        end
        model_cntr = 8'd0;
        run_sweep("rst_rerun", 3, 7, 1, 1, 0, 0);
    endtask

    task automatic test_random();
        int lo;
        int hi;
        for (int n = 0; n < 8; n++) begin
            lo = int'($urandom_range(0, 40));
            hi = lo + int'($urandom_range(1, 12));
            run_sweep("random", lo, hi, int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 3)), 1, 0);
        end
    endtask

    initial begin
        test_reset();
        run_sweep("basic_start_abort", 2, 5, 1, 0, 0, 1);
        run_sweep("dwell", 2, 4, 2, 3, 0, 0);
        test_bad_cfg("lo_eq_hi", 7, 7, 1);
        test_bad_cfg("reps_zero", 1, 9, 0);
        test_bad_cfg("lo_gt_hi", 9, 3, 2);
        run_sweep("full_range", 0, 255, 1, 0, 0, 0);
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
